fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Schedules the single port of a 160x120x12-bit frame-buffer BRAM between two users:
  - VGA scan-out reads, which have fixed priority and hard timing.
  - Buffered pixel writes from a loader (UART or drawing engine) using a valid/ready handshake.
- Sits between vga_controller and the frame-buffer RAM in the 25 MHz pixel domain and drives pixel_rgb.
- Delays hsync/vsync so they stay aligned with the pixels read from the BRAM.

Parameters:
- FB_W, 160, frame-buffer width in pixels (display scale 4x horizontally).
- FB_H, 120, frame-buffer height in pixels (display scale 4x vertically).
- ADDR_W, 15, frame-buffer address width.
- DATA_W, 12, pixel width (RGB444).
- WFIFO_DEPTH, 4, write-buffer entries (power of two).

Ports:
- clk  in  1  25 MHz pixel clock.
- reset  in  1  synchronous, active-high reset.
- curr_x  in  10  pixel column from vga_controller.
- curr_y  in  10  pixel row from vga_controller.
- video_on  in  1  active-region flag from vga_controller.
- hsync_in  in  1  raw hsync from vga_controller.
- vsync_in  in  1  raw vsync from vga_controller.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  target frame-buffer address.
- wr_data  in  DATA_W  pixel to write.
- fb_en  out  1  BRAM enable.
- fb_we  out  1  BRAM write enable.
- fb_addr  out  ADDR_W  BRAM address.
- fb_wdata  out  DATA_W  BRAM write data.
- fb_rdata  in  DATA_W  BRAM read data, valid 1 cycle after a read.
- pixel_rgb  out  DATA_W  aligned pixel output.
- hsync  out  1  hsync delayed by 2 cycles.
- vsync  out  1  vsync delayed by 2 cycles.
- wr_level  out  3  current write-FIFO occupancy (0..WFIFO_DEPTH).
- addr_err  out  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- All state updates on posedge clk. Synchronous active-high reset.
- Reset values:
  - FIFO empty, so wr_level=0 and wr_ready=1.
  - fb_en=0, fb_we=0, fb_addr=0, fb_wdata=0.
  - pixel latch=0, pixel_rgb=0, addr_err=0.
  - hsync/vsync delay registers=1 (inactive), so hsync=vsync=1.
- Reset mid-operation discards all buffered writes. No partial BRAM write occurs after the reset cycle.
- Display read slot:
  - Condition: video_on=1 and curr_x[1:0]==0.
  - fb_addr = (curr_y>>2)*160 + (curr_x>>2), computed as y4*128 + y4*32 + x4 in ADDR_W bits. fb_en=1, fb_we=0.
  - The BRAM port signals are combinational from the slot decision; no bubble.
- Read data path:
  - fb_rdata, valid the cycle after a display read, is registered into the pixel latch.
  - The latch holds its value until the next display read returns.
- Output alignment:
  - video_on, hsync_in and vsync_in each pass through a 2-stage delay.
  - pixel_rgb = video_on_d2 ? latch : 0.
  - A read issued at cycle t for column x is visible at pixel_rgb from t+2 to t+5, covering screen columns x..x+3.
- Write slot:
  - Any cycle without a display read, with FIFO non-empty, pops the FIFO head.
  - Pop drives fb_en=1, fb_we=1, fb_addr=head.addr, fb_wdata=head.data.
  - Display always wins. Writes drain during horizontal/vertical blanking and during the 3 of every 4 active cycles with curr_x[1:0]!=0.
- Idle cycle (no read, FIFO empty): fb_en=0, fb_we=0.
- FIFO push:
  - Push occurs on wr_valid & wr_ready, with wr_ready = (wr_level != WFIFO_DEPTH).
  - When full, wr_ready=0 even if a pop occurs in the same cycle (no combinational ready-through).
  - Push and pop in the same cycle leave wr_level unchanged. Head/tail pointers wrap modulo WFIFO_DEPTH.
- Address range check at push:
  - If wr_addr >= FB_W*FB_H (19200), the handshake still completes (wr_ready honoured).
  - The entry is not stored, and addr_err is set to 1.
  - addr_err clears only on reset.
- No write is ever lost or reordered. BRAM writes occur in acceptance order.

Test Plan:
- Reset check: assert reset 2 cycles while wr_valid=1 and video_on=1 → during and after reset, fb_en=0, wr_level=0, pixel_rgb=0, hsync=vsync=1, addr_err=0.
- Blanking drain: with video_on=0, push 4 writes (addr 0,1,159,19199; data 0xF00,0x0F0,0x00F,0xFFF) back-to-back.
  - wr_ready stays 1 for all 4.
  - BRAM writes appear in order, one per cycle starting the cycle after the first push.
  - wr_level returns to 0.
- Display priority: active line at curr_y=8, curr_x=0..15, FIFO holding 3 writes.
  - fb_addr=320,321,322,323 with fb_we=0 at x=0,4,8,12.
  - The pending writes occupy the x=1,2,3 slots.
  - No write is issued at x%4==0.
- Pixel alignment: preload frame-buffer model addr 320=0xABC.
  - With curr_y=8, curr_x=0, pixel_rgb=0xABC for exactly 4 cycles starting 2 cycles later.
  - hsync/vsync equal the inputs delayed by 2 cycles.
- Full FIFO: during a continuous x%4==0 read pattern, hold wr_valid=1.
  - wr_ready drops to 0 when wr_level=4.
  - wr_ready rises again the cycle after a pop.
  - No entry is overwritten; checked by scoreboard of 8 writes.
- Range error: write addr=19200 data=0x123 → handshake completes, no BRAM write occurs, addr_err=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the single frame-buffer BRAM port between VGA
// scan-out reads (fixed priority) and buffered loader writes, and realigns
// the video timing outputs with the one-cycle BRAM read latency.
module fb_access_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        curr_x,
    input  logic [9:0]        curr_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              fb_en,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic [DATA_W-1:0] pixel_rgb,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        wr_level,
    output logic              addr_err
);

    localparam int PTR_W   = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int FB_SIZE = FB_W * FB_H;

    // Write buffer storage (data only, never reset) and its control state
    logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [2:0]        level_q;
    logic              addr_err_q;

    // Alignment pipeline: read-issued flag, pixel latch, delayed timing
    logic              rd_p1_q;
    logic [DATA_W-1:0] pix_q;
    logic              vid_p1_q, vid_p2_q;
    logic              hs_p1_q, hs_p2_q;
    logic              vs_p1_q, vs_p2_q;

    logic              rd_slot;
    logic              fifo_nonempty;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] rd_addr;

    // Every fourth active column owns the port; the 4x scale means one read
    // serves four screen columns. y4*160 is built as y4*128 + y4*32.
    assign rd_slot       = video_on && (curr_x[1:0] == 2'd0);
    assign rd_addr       = (ADDR_W'(curr_y >> 2) << 7) + (ADDR_W'(curr_y >> 2) << 5)
                         + ADDR_W'(curr_x >> 2);
    assign fifo_nonempty = (level_q != 3'd0);
    // Ready depends only on occupancy so a pop never propagates into ready.
    assign wr_ready      = (level_q != 3'(WFIFO_DEPTH));
    assign in_range      = (wr_addr < ADDR_W'(FB_SIZE));
    assign accept        = wr_valid && wr_ready;
    assign push          = accept && in_range;
    assign pop           = !rd_slot && fifo_nonempty;

    assign wr_level  = level_q;
    assign addr_err  = addr_err_q;
    assign pixel_rgb = vid_p2_q ? pix_q : '0;
    assign hsync     = hs_p2_q;
    assign vsync     = vs_p2_q;

    // Port mux: display read wins, otherwise drain the FIFO head; silent in reset
    always_comb begin
        fb_en    = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (!reset) begin
            if (rd_slot) begin
                fb_en   = 1'b1;
                fb_addr = rd_addr;
            end else if (fifo_nonempty) begin
                fb_en    = 1'b1;
                fb_we    = 1'b1;
                fb_addr  = fifo_addr_q[rptr_q];
                fb_wdata = fifo_data_q[rptr_q];
            end
        end
    end

    // FIFO entry capture at the tail; out-of-range writes are never stored
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    // FIFO pointers/occupancy, sticky range error and output alignment pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= 3'd0;
            addr_err_q <= 1'b0;
            rd_p1_q    <= 1'b0;
            pix_q      <= '0;
            vid_p1_q   <= 1'b0;
            vid_p2_q   <= 1'b0;
            hs_p1_q    <= 1'b1;
            hs_p2_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + 3'd1;
                2'b01:   level_q <= level_q - 3'd1;
                default: level_q <= level_q;
            endcase
            if (accept && !in_range) addr_err_q <= 1'b1;
            // stage 1: BRAM returns data for the read issued last cycle
            rd_p1_q  <= rd_slot;
            if (rd_p1_q) pix_q <= fb_rdata;
            // stage 2: timing signals delayed to match the latched pixel
            vid_p1_q <= video_on;
            vid_p2_q <= vid_p1_q;
            hs_p1_q  <= hsync_in;
            hs_p2_q  <= hs_p1_q;
            vs_p1_q  <= vsync_in;
            vs_p2_q  <= vs_p1_q;
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: BRAM model, write scoreboard, vector table
// for the read-slot decode and hand sequences for the multi-cycle cases.
module tb_fb_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  curr_x, curr_y;
    logic        video_on, hsync_in, vsync_in;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        fb_en, fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_wdata;
    logic [11:0] fb_rdata;
    logic [11:0] pixel_rgb;
    logic        hsync, vsync;
    logic [2:0]  wr_level;
    logic        addr_err;

    int n_vec;
    int n_mis;

    always #20 clk = ~clk;

    fb_access_arbiter dut (
        .clk(clk), .reset(reset), .curr_x(curr_x), .curr_y(curr_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_rdata(fb_rdata), .pixel_rgb(pixel_rgb), .hsync(hsync), .vsync(vsync),
        .wr_level(wr_level), .addr_err(addr_err)
    );

    // Frame-buffer BRAM model: read data appears one cycle after the read
    logic [11:0] mem [0:19199];
    logic [11:0] rdata_q;
    assign fb_rdata = rdata_q;
    always @(posedge clk) begin
        if (fb_en && fb_addr < 15'd19200) begin
            if (fb_we) mem[fb_addr] <= fb_wdata;
            else       rdata_q <= mem[fb_addr];
        end
    end

    // Scoreboard: accepted in-range writes queued, matched against BRAM writes
    typedef struct packed {
        logic [14:0] a;
        logic [11:0] d;
    } wr_t;
    wr_t sbq[$];
    wr_t sb_e;

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
        end else begin
            if (fb_en && fb_we) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", fb_addr, fb_wdata);
                end else begin
                    sb_e = sbq.pop_front();
                    if (fb_addr !== sb_e.a || fb_wdata !== sb_e.d) begin
                        n_mis++;
                        $display("FAIL sb_write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                                 fb_addr, fb_wdata, sb_e.a, sb_e.d);
                    end
                end
            end
            if (wr_valid && wr_ready && wr_addr < 15'd19200)
                sbq.push_back('{a: wr_addr, d: wr_data});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        video_on = 1'b0; curr_x = '0; curr_y = '0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    typedef struct {
        logic        vo;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        en;
        logic        we;
        logic [14:0] addr;
    } vec_t;
    vec_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] dr_a [4];
        logic [11:0] dr_d [4];
        logic [11:0] hpat, vpat, rdy_exp;
        logic        acc;
        int          i_acc;
        int          k;

        tbl[0] = '{1'b1, 10'd0,   10'd8,   1'b1, 1'b0, 15'd320};
        tbl[1] = '{1'b1, 10'd4,   10'd8,   1'b1, 1'b0, 15'd321};
        tbl[2] = '{1'b1, 10'd1,   10'd8,   1'b0, 1'b0, 15'd0};
        tbl[3] = '{1'b0, 10'd0,   10'd8,   1'b0, 1'b0, 15'd0};
        tbl[4] = '{1'b1, 10'd636, 10'd476, 1'b1, 1'b0, 15'd19199};
        tbl[5] = '{1'b1, 10'd12,  10'd0,   1'b1, 1'b0, 15'd3};
        tbl[6] = '{1'b1, 10'd3,   10'd4,   1'b0, 1'b0, 15'd0};
        dr_a[0] = 15'd0;   dr_a[1] = 15'd1;   dr_a[2] = 15'd159;  dr_a[3] = 15'd19199;
        dr_d[0] = 12'hF00; dr_d[1] = 12'h0F0; dr_d[2] = 12'h00F;  dr_d[3] = 12'hFFF;

        n_vec = 0;
        n_mis = 0;

        // Reset with a pending write and an active read slot on the inputs
        idle_inputs();
        reset = 1'b1;
        wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h001;
        video_on = 1'b1; curr_x = 10'd0; curr_y = 10'd8;
        hsync_in = 1'b0; vsync_in = 1'b0;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_fb_en", fb_en, 0);
            chk("rst_wr_level", wr_level, 0);
            chk("rst_wr_ready", wr_ready, 1);
            chk("rst_pixel", pixel_rgb, 0);
            chk("rst_hsync", hsync, 1);
            chk("rst_vsync", vsync, 1);
            chk("rst_addr_err", addr_err, 0);
            next_cycle();
        end
        reset = 1'b0;
        wr_valid = 1'b0; video_on = 1'b0;
        @(negedge clk);
        chk("post_rst_fb_en", fb_en, 0);
        chk("post_rst_wr_level", wr_level, 0);
        chk("post_rst_pixel", pixel_rgb, 0);
        chk("post_rst_hsync", hsync, 1);
        chk("post_rst_vsync", vsync, 1);
        chk("post_rst_addr_err", addr_err, 0);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();

        // Read-slot decode table, FIFO empty
        for (int i = 0; i < 7; i++) begin
            video_on = tbl[i].vo; curr_x = tbl[i].x; curr_y = tbl[i].y;
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), fb_en, tbl[i].en);
            chk($sformatf("tbl%0d_we", i), fb_we, tbl[i].we);
            if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), fb_addr, tbl[i].addr);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Blanking drain: four back-to-back writes, one BRAM write per cycle
        for (int c = 0; c < 6; c++) begin
            wr_valid = (c < 4);
            wr_addr  = (c < 4) ? dr_a[c] : 15'd0;
            wr_data  = (c < 4) ? dr_d[c] : 12'd0;
            @(negedge clk);
            if (c < 4) chk($sformatf("drain_ready%0d", c), wr_ready, 1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("drain_we%0d", c), {fb_en, fb_we}, 2'b11);
                chk($sformatf("drain_addr%0d", c), fb_addr, dr_a[c-1]);
                chk($sformatf("drain_data%0d", c), fb_wdata, dr_d[c-1]);
            end else begin
                chk($sformatf("drain_idle%0d", c), fb_en, 0);
            end
            if (c == 5) chk("drain_level", wr_level, 0);
            next_cycle();
        end

        // Load pixels used by the alignment test through the write path
        for (int c = 0; c < 4; c++) begin
            wr_valid = (c < 2);
            wr_addr  = (c == 0) ? 15'd320 : 15'd321;
            wr_data  = (c == 0) ? 12'hABC : 12'h555;
            next_cycle();
        end
        idle_inputs();

        // Display priority: three writes queued behind continuous read slots
        video_on = 1'b1; curr_y = 10'd8; curr_x = 10'd0;
        for (int c = 0; c < 3; c++) begin
            wr_valid = 1'b1; wr_addr = 15'(1000 + c); wr_data = 12'(12'h100 + c);
            @(negedge clk);
            chk($sformatf("prio_fill_we%0d", c), fb_we, 0);
            next_cycle();
        end
        wr_valid = 1'b0;
        for (int x = 0; x < 16; x++) begin
            curr_x = 10'(x);
            @(negedge clk);
            if (x == 0) chk("prio_level3", wr_level, 3);
            if (x % 4 == 0) begin
                chk($sformatf("prio_rd_x%0d", x), {fb_en, fb_we}, 2'b10);
                chk($sformatf("prio_addr_x%0d", x), fb_addr, 320 + x / 4);
            end else if (x < 4) begin
                chk($sformatf("prio_wr_x%0d", x), {fb_en, fb_we}, 2'b11);
                chk($sformatf("prio_waddr_x%0d", x), fb_addr, 1000 + x - 1);
            end else begin
                chk($sformatf("prio_idle_x%0d", x), fb_en, 0);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        // Pixel alignment and sync delay
        hpat = 12'b1011_0011_1010;
        vpat = 12'b0110_1100_0101;
        for (int c = 0; c < 12; c++) begin
            video_on = (c >= 2 && c < 10);
            curr_x   = (c >= 2) ? 10'(c - 2) : 10'd0;
            curr_y   = 10'd8;
            hsync_in = hpat[c];
            vsync_in = vpat[c];
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("align_hsync%0d", c), hsync, hpat[c-2]);
                chk($sformatf("align_vsync%0d", c), vsync, vpat[c-2]);
            end
            if (c >= 4 && c <= 7)       chk($sformatf("align_pix%0d", c), pixel_rgb, 12'hABC);
            else if (c >= 8 && c <= 11) chk($sformatf("align_pix%0d", c), pixel_rgb, 12'h555);
            else                        chk($sformatf("align_pix%0d", c), pixel_rgb, 0);
            next_cycle();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        chk("align_pix_off", pixel_rgb, 0);
        next_cycle();

        // Full FIFO under read pressure, eight writes held valid
        rdy_exp = 12'b1000_1000_1111;
        i_acc = 0;
        for (int c = 0; c < 30; c++) begin
            video_on = (c < 10);
            curr_x   = (c == 6) ? 10'd1 : 10'd0;
            curr_y   = 10'd8;
            wr_valid = (i_acc < 8);
            wr_addr  = 15'(2000 + i_acc);
            wr_data  = 12'(12'h200 + i_acc);
            @(negedge clk);
            if (c < 12) chk($sformatf("full_ready%0d", c), wr_ready, rdy_exp[c]);
            if (c == 4) chk("full_level4", wr_level, 4);
            acc = wr_valid && wr_ready;
            next_cycle();
            if (acc) i_acc++;
        end
        idle_inputs();
        @(negedge clk);
        chk("full_accepted", i_acc, 8);
        chk("full_drained", wr_level, 0);
        chk("full_sb_empty", sbq.size(), 0);
        next_cycle();

        // Out-of-range write: handshake completes, nothing stored, sticky flag
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'h123;
        @(negedge clk);
        chk("range_ready", wr_ready, 1);
        chk("range_err_before", addr_err, 0);
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("range_err_set", addr_err, 1);
        chk("range_no_write", fb_en, 0);
        chk("range_level", wr_level, 0);
        next_cycle();
        for (k = 0; k < 3; k++) next_cycle();
        @(negedge clk);
        chk("range_err_sticky", addr_err, 1);
        next_cycle();

        // Reset mid-operation discards buffered writes and clears the flag
        video_on = 1'b1; curr_x = 10'd0; curr_y = 10'd8;
        for (int c = 0; c < 2; c++) begin
            wr_valid = 1'b1; wr_addr = 15'(3000 + c); wr_data = 12'h3A0;
            next_cycle();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("mid_level2", wr_level, 2);
        next_cycle();
        reset = 1'b1;
        video_on = 1'b0;
        @(negedge clk);
        chk("mid_rst_fb_en", fb_en, 0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_post_fb_en%0d", c), fb_en, 0);
            chk($sformatf("mid_post_level%0d", c), wr_level, 0);
            chk($sformatf("mid_post_err%0d", c), addr_err, 0);
            next_cycle();
        end

        @(negedge clk);
        chk("final_sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
